// File: rtl/opcode_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | opcode_sequencer_if                                                        |
// | Program-load, opcode/result and result-readback bundle of opcode_sequencer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface opcode_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [19:0]   load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic [18:0]   opcode_out;
    logic [7:0]    result_in;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   exec_count;

    // master: the sequencer; slave: host loader plus the CPU it drives
    modport master (
        input  load_en, load_addr, load_data, prog_len, start, result_in, rd_addr,
        output opcode_out, rd_data, busy, done, exec_count
    );

    modport slave (
        output load_en, load_addr, load_data, prog_len, start, result_in, rd_addr,
        input  opcode_out, rd_data, busy, done, exec_count
    );
endinterface

`default_nettype wire

// File: rtl/opcode_sequencer.sv
// +----------------------------------------------------------------------------+
// | opcode_sequencer                                                           |
// | Steps a loaded program through the CPU opcode bus and buffers each result. |
// | Optional macro RESULT_FWD_EN: word bit 19 forwards last result to operand1 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module opcode_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    opcode_sequencer_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);
`ifdef RESULT_FWD_EN
    localparam int          PW      = 20;
`else
    localparam int          PW      = 19;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   exec_q, exec_d;
    logic [18:0]   opcode_q, opcode_d;
    logic [PW-1:0] prog_mem [DEPTH];
    logic [7:0]    res_buf  [DEPTH];

    logic          w_issue;
    logic [AW:0]   w_iss_pc;
    logic [AW:0]   w_iss_len;
    logic [PW-1:0] w_iss_word;
    logic [AW:0]   w_pc_inc;
    logic [AW:0]   w_len_clamp;
    logic [PW-1:0] w_fetch0;

`ifdef RESULT_FWD_EN
    logic [7:0]    last_res_q, last_res_d;
    logic [7:0]    w_iss_last;
`else
    logic          w_unused_fwd;
    assign w_unused_fwd = bus.load_data[19];
`endif

    assign w_pc_inc    = pc_q + C_ONE;
    assign w_len_clamp = (bus.prog_len > C_DEPTH) ? C_DEPTH : bus.prog_len;
    // A write to address 0 in the start cycle must be the word that issues
    assign w_fetch0    = (bus.load_en && (bus.load_addr == '0)) ? bus.load_data[PW-1:0]
                                                                 : prog_mem[0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        exec_d     = exec_q;
        opcode_d   = opcode_q;
        w_issue    = 1'b0;
        w_iss_pc   = pc_q;
        w_iss_len  = len_q;
        w_iss_word = prog_mem[pc_q[AW-1:0]];
`ifdef RESULT_FWD_EN
        last_res_d = last_res_q;
        w_iss_last = last_res_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d      = w_len_clamp;
                    exec_d     = '0;
                    pc_d       = '0;
                    w_issue    = 1'b1;
                    w_iss_pc   = '0;
                    w_iss_len  = w_len_clamp;
                    w_iss_word = w_fetch0;
`ifdef RESULT_FWD_EN
                    last_res_d = '0;
                    w_iss_last = '0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                exec_d     = exec_q + C_ONE;
                pc_d       = w_pc_inc;
                w_issue    = 1'b1;
                w_iss_pc   = w_pc_inc;
                w_iss_word = prog_mem[w_pc_inc[AW-1:0]];
`ifdef RESULT_FWD_EN
                last_res_d = bus.result_in;
                w_iss_last = bus.result_in;
`endif
            end
            S_DONE: begin
                opcode_d = '0;
                state_d  = S_IDLE;
            end
        endcase

        // Issue step; the pc==len test guards the wrapped fetch index at pc==DEPTH
        if (w_issue) begin
            if ((w_iss_pc == w_iss_len) || (w_iss_word[18:16] == 3'b000)) begin
                state_d = S_DONE;
            end else begin
                opcode_d = w_iss_word[18:0];
`ifdef RESULT_FWD_EN
                if (w_iss_word[19]) begin
                    opcode_d[15:8] = w_iss_last;
                end
`endif
                state_d = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            exec_q     <= '0;
            opcode_q   <= '0;
`ifdef RESULT_FWD_EN
            last_res_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            exec_q     <= exec_d;
            opcode_q   <= opcode_d;
`ifdef RESULT_FWD_EN
            last_res_q <= last_res_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_buf[i] <= '0;
            end
        end else if (state_q == S_CAPTURE) begin
            res_buf[pc_q[AW-1:0]] <= bus.result_in;
        end
    end

    // Program memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (bus.load_en && (state_q == S_IDLE)) begin
            prog_mem[bus.load_addr] <= bus.load_data[PW-1:0];
        end
    end

    assign bus.opcode_out = opcode_q;
    assign bus.rd_data    = res_buf[bus.rd_addr];
    assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_CAPTURE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.exec_count = exec_q;

endmodule

`default_nettype wire

// File: tb/tb_opcode_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_opcode_sequencer                                                        |
// | Directed self-checking bench for opcode_sequencer with a behavioural CPU.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_opcode_sequencer;
    logic clk;
    logic rst_n;
    int   vec;
    int   miss;
    logic [18:0] seen [$];

    opcode_sequencer_if #(.DEPTH(16)) bus ();

    opcode_sequencer #(.DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in CPU: 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 INC, 111 DEC
    function automatic logic [7:0] cpu(input logic [18:0] op);
        logic [7:0] a;
        logic [7:0] b;
        a = op[15:8];
        b = op[7:0];
        case (op[18:16])
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a + 8'd1;
            3'd7:    return a - 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.result_in = cpu(bus.opcode_out);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [19:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        tick();
        bus.load_en   = 1'b0;
    endtask

    // Starts a run, returns cycles from start edge to done and busy samples
    task automatic run(input logic [4:0] len, output int n, output int busy_n);
        seen.delete();
        busy_n       = 0;
        n            = 0;
        bus.prog_len = len;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.load_en  = 1'b0;
        if (bus.busy) begin
            busy_n++;
            seen.push_back(bus.opcode_out);
        end
        while (!bus.done && n < 200) begin
            tick();
            n++;
            if (bus.busy) begin
                busy_n++;
                if (seen.size() == 0 || seen[$] != bus.opcode_out) seen.push_back(bus.opcode_out);
            end
        end
        vec++;
        if (!bus.done) begin
            miss++;
            $display("FAIL run_timeout done=%0b after %0d cycles, required done=1", bus.done, n);
        end
        tick();
    endtask

    task automatic test_reset();
        bus.rd_addr = 4'd0;
        #1;
        vec++; if (bus.opcode_out !== 19'h0) begin miss++; $display("FAIL reset_opcode got=%0h exp=0", bus.opcode_out); end
        vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        vec++; if (bus.done !== 1'b0) begin miss++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        vec++; if (bus.exec_count !== 5'd0) begin miss++; $display("FAIL reset_exec got=%0d exp=0", bus.exec_count); end
        vec++; if (bus.rd_data !== 8'h00) begin miss++; $display("FAIL reset_res0 got=%0h exp=0", bus.rd_data); end
        bus.rd_addr = 4'd15;
        #1;
        vec++; if (bus.rd_data !== 8'h00) begin miss++; $display("FAIL reset_res15 got=%0h exp=0", bus.rd_data); end
    endtask

    task automatic test_basic();
        int n;
        int bn;
        load(4'd0, 20'h10503);
        load(4'd1, 20'h20A03);
        run(5'd2, n, bn);
        vec++; if (n !== 4) begin miss++; $display("FAIL basic_done_cycle got=%0d exp=4", n); end
        vec++; if (bn !== 4) begin miss++; $display("FAIL basic_busy_cycles got=%0d exp=4", bn); end
        vec++; if (seen.size() !== 2) begin miss++; $display("FAIL basic_issue_count got=%0d exp=2", seen.size()); end
        if (seen.size() == 2) begin
            vec++; if (seen[0] !== 19'h10503) begin miss++; $display("FAIL basic_op0 got=%0h exp=10503", seen[0]); end
            vec++; if (seen[1] !== 19'h20A03) begin miss++; $display("FAIL basic_op1 got=%0h exp=20a03", seen[1]); end
        end
        vec++; if (bus.exec_count !== 5'd2) begin miss++; $display("FAIL basic_exec got=%0d exp=2", bus.exec_count); end
        vec++; if (bus.done !== 1'b0) begin miss++; $display("FAIL basic_done_pulse got=%0b exp=0", bus.done); end
        vec++; if (bus.opcode_out !== 19'h0) begin miss++; $display("FAIL basic_idle_opcode got=%0h exp=0", bus.opcode_out); end
        bus.rd_addr = 4'd0; #1;
        vec++; if (bus.rd_data !== 8'h08) begin miss++; $display("FAIL basic_res0 got=%0h exp=08", bus.rd_data); end
        bus.rd_addr = 4'd1; #1;
        vec++; if (bus.rd_data !== 8'h07) begin miss++; $display("FAIL basic_res1 got=%0h exp=07", bus.rd_data); end
    endtask

    task automatic test_halt();
        int n;
        int bn;
        load(4'd0, 20'h3F03C);
        load(4'd1, 20'h01122);
        load(4'd2, 20'h40102);
        run(5'd3, n, bn);
        vec++; if (n !== 2) begin miss++; $display("FAIL halt_done_cycle got=%0d exp=2", n); end
        vec++; if (seen.size() !== 1) begin miss++; $display("FAIL halt_issue_count got=%0d exp=1", seen.size()); end
        vec++; if (bus.exec_count !== 5'd1) begin miss++; $display("FAIL halt_exec got=%0d exp=1", bus.exec_count); end
        bus.rd_addr = 4'd0; #1;
        vec++; if (bus.rd_data !== 8'h30) begin miss++; $display("FAIL halt_res0 got=%0h exp=30", bus.rd_data); end
        bus.rd_addr = 4'd1; #1;
        vec++; if (bus.rd_data !== 8'h07) begin miss++; $display("FAIL halt_res1_kept got=%0h exp=07", bus.rd_data); end
        bus.rd_addr = 4'd2; #1;
        vec++; if (bus.rd_data !== 8'h00) begin miss++; $display("FAIL halt_res2_kept got=%0h exp=00", bus.rd_data); end
    endtask

    task automatic test_zero_len();
        int n;
        int bn;
        run(5'd0, n, bn);
        vec++; if (n !== 0) begin miss++; $display("FAIL zero_done_cycle got=%0d exp=0", n); end
        vec++; if (bn !== 0) begin miss++; $display("FAIL zero_busy got=%0d exp=0", bn); end
        vec++; if (bus.exec_count !== 5'd0) begin miss++; $display("FAIL zero_exec got=%0d exp=0", bus.exec_count); end
        vec++; if (bus.done !== 1'b0) begin miss++; $display("FAIL zero_done_pulse got=%0b exp=0", bus.done); end
    endtask

    task automatic test_clamp();
        int n;
        int bn;
        for (int i = 0; i < 16; i++) begin
            load(4'(i), {4'b0001, 8'(i), 8'h01});
        end
        run(5'd31, n, bn);
        vec++; if (n !== 32) begin miss++; $display("FAIL clamp_done_cycle got=%0d exp=32", n); end
        vec++; if (bus.exec_count !== 5'd16) begin miss++; $display("FAIL clamp_exec got=%0d exp=16", bus.exec_count); end
        bus.rd_addr = 4'd15; #1;
        vec++; if (bus.rd_data !== 8'h10) begin miss++; $display("FAIL clamp_res15 got=%0h exp=10", bus.rd_data); end
        bus.rd_addr = 4'd0; #1;
        vec++; if (bus.rd_data !== 8'h01) begin miss++; $display("FAIL clamp_res0 got=%0h exp=01", bus.rd_data); end
    endtask

    task automatic test_start_with_load();
        int n;
        int bn;
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd0;
        bus.load_data = 20'h40FF0;
        run(5'd1, n, bn);
        vec++; if (seen.size() !== 1 || seen[0] !== 19'h40FF0) begin miss++; $display("FAIL startload_op got=%0h exp=40ff0", (seen.size() > 0) ? seen[0] : 19'h0); end
        bus.rd_addr = 4'd0; #1;
        vec++; if (bus.rd_data !== 8'hFF) begin miss++; $display("FAIL startload_res0 got=%0h exp=ff", bus.rd_data); end
    endtask

    task automatic test_busy_ignore();
        int n;
        int bn;
        load(4'd0, 20'h10503);
        load(4'd1, 20'h20A03);
        bus.prog_len  = 5'd2;
        bus.start     = 1'b1;
        tick();
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd0;
        bus.load_data = 20'h7FFFF;
        n = 0;
        while (!bus.done && n < 50) begin
            tick();
            n++;
        end
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        vec++; if (n !== 4) begin miss++; $display("FAIL busy_done_cycle got=%0d exp=4", n); end
        tick();
        vec++; if (bus.exec_count !== 5'd2) begin miss++; $display("FAIL busy_exec got=%0d exp=2", bus.exec_count); end
        vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL busy_no_restart got=%0b exp=0", bus.busy); end
        bus.rd_addr = 4'd1; #1;
        vec++; if (bus.rd_data !== 8'h07) begin miss++; $display("FAIL busy_res1 got=%0h exp=07", bus.rd_data); end
        run(5'd1, n, bn);
        vec++; if (seen.size() !== 1 || seen[0] !== 19'h10503) begin miss++; $display("FAIL busy_mem_kept got=%0h exp=10503", (seen.size() > 0) ? seen[0] : 19'h0); end
        bus.rd_addr = 4'd0; #1;
        vec++; if (bus.rd_data !== 8'h08) begin miss++; $display("FAIL busy_rerun_res0 got=%0h exp=08", bus.rd_data); end
    endtask

    task automatic test_forward();
        int n;
        int bn;
        logic [7:0]  exp_res1;
        logic [18:0] exp_op1;
`ifdef RESULT_FWD_EN
        exp_res1 = 8'h01;
        exp_op1  = 19'h10001;
`else
        exp_res1 = 8'h11;
        exp_op1  = 19'h11001;
`endif
        load(4'd0, 20'h6FF00);
        load(4'd1, 20'h91001);
        run(5'd2, n, bn);
        vec++; if (seen.size() !== 2 || seen[1] !== exp_op1) begin miss++; $display("FAIL fwd_op1 got=%0h exp=%0h", (seen.size() > 1) ? seen[1] : 19'h0, exp_op1); end
        bus.rd_addr = 4'd0; #1;
        vec++; if (bus.rd_data !== 8'h00) begin miss++; $display("FAIL fwd_res0 got=%0h exp=00", bus.rd_data); end
        bus.rd_addr = 4'd1; #1;
        vec++; if (bus.rd_data !== exp_res1) begin miss++; $display("FAIL fwd_res1 got=%0h exp=%0h", bus.rd_data, exp_res1); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int bn;
        load(4'd0, 20'h10101);
        load(4'd1, 20'h20904);
        load(4'd2, 20'h5AA55);
        load(4'd3, 20'h71000);
        bus.prog_len = 5'd4;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        bus.rd_addr = 4'd0;
        #1;
        vec++; if (bus.opcode_out !== 19'h0) begin miss++; $display("FAIL midrst_opcode got=%0h exp=0", bus.opcode_out); end
        vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
        vec++; if (bus.exec_count !== 5'd0) begin miss++; $display("FAIL midrst_exec got=%0d exp=0", bus.exec_count); end
        vec++; if (bus.rd_data !== 8'h00) begin miss++; $display("FAIL midrst_res0 got=%0h exp=00", bus.rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run(5'd4, n, bn);
        vec++; if (n !== 8) begin miss++; $display("FAIL midrst_rerun_cycles got=%0d exp=8", n); end
        vec++; if (bus.exec_count !== 5'd4) begin miss++; $display("FAIL midrst_rerun_exec got=%0d exp=4", bus.exec_count); end
        bus.rd_addr = 4'd0; #1;
        vec++; if (bus.rd_data !== 8'h02) begin miss++; $display("FAIL midrst_res0b got=%0h exp=02", bus.rd_data); end
        bus.rd_addr = 4'd1; #1;
        vec++; if (bus.rd_data !== 8'h05) begin miss++; $display("FAIL midrst_res1 got=%0h exp=05", bus.rd_data); end
        bus.rd_addr = 4'd2; #1;
        vec++; if (bus.rd_data !== 8'hFF) begin miss++; $display("FAIL midrst_res2 got=%0h exp=ff", bus.rd_data); end
        bus.rd_addr = 4'd3; #1;
        vec++; if (bus.rd_data !== 8'h0F) begin miss++; $display("FAIL midrst_res3 got=%0h exp=0f", bus.rd_data); end
    endtask

    initial begin
        vec           = 0;
        miss          = 0;
        rst_n         = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.rd_addr   = '0;
        tick();
        tick();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_basic();
        test_halt();
        test_zero_len();
        test_clamp();
        test_start_with_load();
        test_busy_ignore();
        test_forward();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

`default_nettype wire
